// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED sizing function, scrub FSM state type and event counter width
package ecc_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WB} scrub_e;
  function automatic int chk_bits(int xlen);
    int p = 1;
    while ((1 << p) < xlen + p + 1) p++;
    return p;
  endfunction
endpackage

// File: rtl/ecc_regfile_if.sv
// ecc_regfile_if: write/read/inject/counter bus of ecc_regfile; master drives requests, slave returns data, flags, counters, scrub_busy
interface ecc_regfile_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 16
) ();
  localparam int AW = $clog2(NREGS);
  localparam int CW = XLEN + ecc_pkg::chk_bits(XLEN) + 1;
  logic we;
  logic [AW-1:0] waddr;
  logic [XLEN-1:0] wd;
  logic [AW-1:0] rs1, rs2;
  logic re1, re2;
  logic [XLEN-1:0] rd1, rd2;
  logic rd1_ce, rd1_ue, rd2_ce, rd2_ue;
  logic inj_en;
  logic [AW-1:0] inj_addr;
  logic [CW-1:0] inj_mask;
  logic clr_cnt;
  logic [ecc_pkg::CNT_W-1:0] ce_count, ue_count;
  logic scrub_busy;
  modport master (
    output we, waddr, wd, rs1, rs2, re1, re2, inj_en, inj_addr, inj_mask, clr_cnt,
    input rd1, rd2, rd1_ce, rd1_ue, rd2_ce, rd2_ue, ce_count, ue_count, scrub_busy
  );
  modport slave (
    input we, waddr, wd, rs1, rs2, re1, re2, inj_en, inj_addr, inj_mask, clr_cnt,
    output rd1, rd2, rd1_ce, rd1_ue, rd2_ce, rd2_ue, ce_count, ue_count, scrub_busy
  );
endinterface

// File: rtl/secded_codec.sv
// secded_codec: extended-Hamming SECDED; enc_data_i->enc_cw_o encode, dec_cw_i->dec_data_o/dec_ce_o/dec_ue_o decode (bit 0 = overall parity, bits 1..N = Hamming positions)
module secded_codec import ecc_pkg::*; #(
  parameter int XLEN = 32,
  localparam int P = chk_bits(XLEN),
  localparam int N = XLEN + P,
  localparam int CW = N + 1
) (
  input  logic [XLEN-1:0] enc_data_i,
  output logic [CW-1:0]   enc_cw_o,
  input  logic [CW-1:0]   dec_cw_i,
  output logic [XLEN-1:0] dec_data_o,
  output logic            dec_ce_o,
  output logic            dec_ue_o
);
  localparam logic [P-1:0] NL = P'(N);
  function automatic logic [CW-1:0] msk(int p);
    msk = '0;
    for (int j = 1; j < CW; j++) msk[j] = (j & p) != 0;
  endfunction
  logic [CW-1:0] dvec;
  logic [N:1] h;
  logic [P-1:0] syn;
  logic ov;
  assign dvec[0] = 1'b0;
  for (genvar i = 1; i <= N; i++) begin : g_pos
    if ((i & (i - 1)) != 0) begin : g_d
      assign dvec[i] = enc_data_i[i-1-$clog2(i+1)];
      assign h[i] = dvec[i];
      assign dec_data_o[i-1-$clog2(i+1)] = dec_cw_i[i] ^ (dec_ce_o && syn == P'(i));
    end else begin : g_c
      assign dvec[i] = 1'b0;
      assign h[i] = ^(dvec & msk(i));
    end
  end
  for (genvar b = 0; b < P; b++) begin : g_syn
    assign syn[b] = ^(dec_cw_i & msk(1 << b));
  end
  assign enc_cw_o = {h, ^h};
  assign ov = ^dec_cw_i;
  // odd overall parity with a syndrome beyond the codeword can only come from 3+ flips
  assign dec_ce_o = ov && syn <= NL;
  assign dec_ue_o = ov ? syn > NL : syn != '0;
endmodule

// File: rtl/ecc_regfile.sv
// ecc_regfile: SECDED register file, 2 comb read ports with write-first bypass, fault injection, saturating CE/UE counters, background scrubber; clk, rst (sync, active-high), bus (ecc_regfile_if.slave)
module ecc_regfile import ecc_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREGS = 16,
  parameter int SCRUB_INTERVAL = 64
) (
  input logic clk,
  input logic rst,
  ecc_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = XLEN + chk_bits(XLEN) + 1;
  localparam int IW = SCRUB_INTERVAL > 0 ? $clog2(SCRUB_INTERVAL + 1) : 1;
  logic [CW-1:0] mem_q [NREGS];
  logic [CW-1:0] wcw, unused_enc1, unused_enc2;
  logic [XLEN-1:0] d1, d2, sd, sdata_q, sdata_d;
  logic c1, u1, c2, u2, sc, su;
  logic hit1, hit2, shit, s_ce, s_ue, scrub_wr, adv, ce_inc, ue_inc, inj_ok;
  scrub_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ce_q, ce_d, ue_q, ue_d;
  secded_codec #(.XLEN(XLEN)) u_rd1 (
    .enc_data_i('0), .enc_cw_o(unused_enc1), .dec_cw_i(mem_q[bus.rs1]),
    .dec_data_o(d1), .dec_ce_o(c1), .dec_ue_o(u1)
  );
  secded_codec #(.XLEN(XLEN)) u_rd2 (
    .enc_data_i('0), .enc_cw_o(unused_enc2), .dec_cw_i(mem_q[bus.rs2]),
    .dec_data_o(d2), .dec_ce_o(c2), .dec_ue_o(u2)
  );
  // functional writes and scrub writebacks are mutually exclusive, so one encoder serves both
  secded_codec #(.XLEN(XLEN)) u_scrub (
    .enc_data_i(bus.we ? bus.wd : sdata_q), .enc_cw_o(wcw), .dec_cw_i(mem_q[ptr_q]),
    .dec_data_o(sd), .dec_ce_o(sc), .dec_ue_o(su)
  );
  assign hit1 = bus.we && bus.rs1 == bus.waddr;
  assign hit2 = bus.we && bus.rs2 == bus.waddr;
  assign shit = bus.we && bus.waddr == ptr_q;
  assign bus.rd1 = hit1 ? bus.wd : d1;
  assign bus.rd2 = hit2 ? bus.wd : d2;
  assign bus.rd1_ce = !hit1 && c1;
  assign bus.rd1_ue = !hit1 && u1;
  assign bus.rd2_ce = !hit2 && c2;
  assign bus.rd2_ue = !hit2 && u2;
  assign bus.ce_count = ce_q;
  assign bus.ue_count = ue_q;
  assign bus.scrub_busy = state_q != S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      icnt_q <= IW'(SCRUB_INTERVAL);
      sdata_q <= '0;
      ce_q <= '0;
      ue_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      icnt_q <= icnt_d;
      sdata_q <= sdata_d;
      ce_q <= ce_d;
      ue_q <= ue_d;
    end
  end
  always_comb begin
    state_d = state_q == S_IDLE ? ((SCRUB_INTERVAL != 0 && icnt_q == '0) ? S_RD : S_IDLE)
            : state_q == S_RD ? (s_ce ? S_WB : S_IDLE)
            : (bus.we && !shit) ? S_WB : S_IDLE;
  end
  // a same-cycle functional write to the scrubbed entry makes it clean, so the scrubber skips it
  always_comb begin
    s_ce = state_q == S_RD && sc && !shit;
    s_ue = state_q == S_RD && su && !shit;
    scrub_wr = state_q == S_WB && !bus.we;
    adv = (state_q == S_RD && !s_ce) || (state_q == S_WB && !(bus.we && !shit));
    ptr_d = adv ? ptr_q + AW'(1) : ptr_q;
    icnt_d = adv ? IW'(SCRUB_INTERVAL) : (state_q == S_IDLE && icnt_q != '0) ? icnt_q - IW'(1) : icnt_q;
    sdata_d = s_ce ? sd : sdata_q;
    ce_inc = (bus.re1 && bus.rd1_ce) || (bus.re2 && bus.rd2_ce) || s_ce;
    ue_inc = (bus.re1 && bus.rd1_ue) || (bus.re2 && bus.rd2_ue) || s_ue;
    ce_d = bus.clr_cnt ? '0 : (ce_inc && ce_q != '1) ? ce_q + CNT_W'(1) : ce_q;
    ue_d = bus.clr_cnt ? '0 : (ue_inc && ue_q != '1) ? ue_q + CNT_W'(1) : ue_q;
    inj_ok = bus.inj_en && !(bus.we && bus.waddr == bus.inj_addr) && !(scrub_wr && ptr_q == bus.inj_addr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      if (bus.we || scrub_wr) mem_q[bus.we ? bus.waddr : ptr_q] <= wcw;
      if (inj_ok) mem_q[bus.inj_addr] <= mem_q[bus.inj_addr] ^ bus.inj_mask;
    end
  end
endmodule

// File: tb/tb_ecc_regfile.sv
// tb_ecc_regfile: randomized check of ecc_regfile against a data/error-mask reference model plus directed scrub scenarios
module tb_ecc_regfile;
  import ecc_pkg::*;
  localparam int XLEN = 32;
  localparam int NREGS = 16;
  localparam int AW = 4;
  localparam int CW = 39;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ecc_regfile_if #(.XLEN(XLEN), .NREGS(NREGS)) mi ();
  ecc_regfile_if #(.XLEN(XLEN), .NREGS(NREGS)) si ();
  ecc_regfile #(.XLEN(XLEN), .NREGS(NREGS), .SCRUB_INTERVAL(0)) u_main (.clk(clk), .rst(rst), .bus(mi.slave));
  ecc_regfile #(.XLEN(XLEN), .NREGS(NREGS), .SCRUB_INTERVAL(4)) u_scrub (.clk(clk), .rst(rst), .bus(si.slave));
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] m_data [NREGS];
  logic [CW-1:0] m_err [NREGS];
  int m_ce, m_ue;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_data[i] = '0;
      m_err[i] = '0;
    end
    m_ce = 0;
    m_ue = 0;
  endtask
  task automatic m_idle();
    mi.we = 0; mi.waddr = '0; mi.wd = '0; mi.rs1 = '0; mi.rs2 = '0; mi.re1 = 0; mi.re2 = 0;
    mi.inj_en = 0; mi.inj_addr = '0; mi.inj_mask = '0; mi.clr_cnt = 0;
  endtask
  task automatic s_idle();
    si.we = 0; si.waddr = '0; si.wd = '0; si.rs1 = '0; si.rs2 = '0; si.re1 = 0; si.re2 = 0;
    si.inj_en = 0; si.inj_addr = '0; si.inj_mask = '0; si.clr_cnt = 0;
  endtask
  task automatic port_check(string tag, logic [AW-1:0] rs, logic [XLEN-1:0] rd, logic ce, logic ue,
                            output logic ece, output logic eue);
    int n;
    logic byp;
    byp = mi.we && rs == mi.waddr;
    n = byp ? 0 : $countones(m_err[rs]);
    ece = n == 1;
    eue = n == 2;
    if (n < 2) check({tag, "_data"}, 64'(rd), byp ? 64'(mi.wd) : 64'(m_data[rs]));
    check({tag, "_ce"}, 64'(ce), 64'(ece));
    check({tag, "_ue"}, 64'(ue), 64'(eue));
  endtask
  task automatic step();
    logic e1c, e1u, e2c, e2u;
    @(negedge clk);
    port_check("rd1", mi.rs1, mi.rd1, mi.rd1_ce, mi.rd1_ue, e1c, e1u);
    port_check("rd2", mi.rs2, mi.rd2, mi.rd2_ce, mi.rd2_ue, e2c, e2u);
    check("ce_count", 64'(mi.ce_count), 64'(m_ce));
    check("ue_count", 64'(mi.ue_count), 64'(m_ue));
    if (mi.clr_cnt) begin
      m_ce = 0;
      m_ue = 0;
    end else begin
      if ((mi.re1 && e1c) || (mi.re2 && e2c)) m_ce = m_ce < 65535 ? m_ce + 1 : m_ce;
      if ((mi.re1 && e1u) || (mi.re2 && e2u)) m_ue = m_ue < 65535 ? m_ue + 1 : m_ue;
    end
    if (mi.inj_en && !(mi.we && mi.waddr == mi.inj_addr)) m_err[mi.inj_addr] = m_err[mi.inj_addr] ^ mi.inj_mask;
    if (mi.we) begin
      m_data[mi.waddr] = mi.wd;
      m_err[mi.waddr] = '0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_inputs();
    logic [CW-1:0] m;
    logic [AW-1:0] a;
    m_idle();
    mi.we = ($urandom % 4) == 0;
    mi.waddr = AW'($urandom);
    mi.wd = $urandom;
    mi.rs1 = AW'($urandom);
    mi.rs2 = AW'($urandom);
    mi.re1 = 1'($urandom);
    mi.re2 = 1'($urandom);
    mi.clr_cnt = ($urandom % 40) == 0;
    if (($urandom % 3) == 0) begin
      a = AW'($urandom);
      m = CW'(1) << $urandom_range(0, CW - 1);
      if ($urandom % 2 == 1) m = m | (CW'(1) << $urandom_range(0, CW - 1));
      if ($countones(m_err[a] ^ m) <= 2) begin
        mi.inj_en = 1;
        mi.inj_addr = a;
        mi.inj_mask = m;
      end
    end
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n;
    m_idle();
    s_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd1", 64'(mi.rd1), 0);
    check("rst_rd2", 64'(mi.rd2), 0);
    check("rst_flags", 64'({mi.rd1_ce, mi.rd1_ue, mi.rd2_ce, mi.rd2_ue}), 0);
    check("rst_ce_count", 64'(mi.ce_count), 0);
    check("rst_ue_count", 64'(mi.ue_count), 0);
    check("rst_busy", 64'(si.scrub_busy), 0);
    rst = 0;
    mi.we = 1; mi.waddr = 3; mi.wd = 32'hDEADBEEF; mi.rs1 = 3;
    step();
    m_idle(); mi.rs1 = 3; #1;
    check("r3_read", 64'(mi.rd1), 64'h0000_0000_DEAD_BEEF);
    check("r3_clean", 64'({mi.rd1_ce, mi.rd1_ue}), 0);
    step();
    mi.inj_en = 1; mi.inj_addr = 3; mi.inj_mask = CW'(1) << 5;
    step();
    m_idle(); mi.rs1 = 3; mi.re1 = 1; #1;
    check("r3_corr_data", 64'(mi.rd1), 64'h0000_0000_DEAD_BEEF);
    check("r3_corr_ce", 64'({mi.rd1_ce, mi.rd1_ue}), 2);
    step();
    check("ce_count_one", 64'(mi.ce_count), 1);
    m_idle(); mi.inj_en = 1; mi.inj_addr = 7; mi.inj_mask = (CW'(1) << 9) | CW'(1);
    step();
    m_idle(); mi.rs1 = 7; mi.re1 = 1; #1;
    check("r7_ue", 64'({mi.rd1_ce, mi.rd1_ue}), 1);
    step();
    check("ue_count_one", 64'(mi.ue_count), 1);
    mi.rs2 = 7; mi.re2 = 1;
    step();
    check("ue_count_dual", 64'(mi.ue_count), 2);
    m_idle(); mi.we = 1; mi.waddr = 5; mi.wd = 32'hCAFE0123; mi.rs2 = 5; #1;
    check("bypass_rd2", 64'(mi.rd2), 64'h0000_0000_CAFE_0123);
    step();
    repeat (3000) begin
      rand_inputs();
      step();
    end
    m_idle(); mi.clr_cnt = 1;
    step();
    m_idle(); mi.we = 1; mi.waddr = 1; mi.wd = 32'h55AA_33CC;
    step();
    m_idle(); mi.inj_en = 1; mi.inj_addr = 1; mi.inj_mask = CW'(1);
    step();
    m_idle(); mi.rs1 = 1; mi.re1 = 1;
    repeat (65535) @(posedge clk);
    #1;
    m_ce = m_ce + 65535 > 65535 ? 65535 : m_ce + 65535;
    check("ce_sat", 64'(mi.ce_count), 64'(m_ce));
    step();
    check("ce_sat_hold", 64'(mi.ce_count), 64'hFFFF);
    mi.clr_cnt = 1;
    step();
    check("clr_over_inc", 64'(mi.ce_count), 0);
    m_idle();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    si.we = 1; si.waddr = 2; si.wd = 32'h0BADF00D;
    @(posedge clk); #1;
    s_idle(); si.inj_en = 1; si.inj_addr = 2; si.inj_mask = CW'(1) << 7;
    @(posedge clk); #1;
    s_idle();
    n = 0;
    while (si.ce_count == 0 && n < 96) begin
      @(posedge clk); #1;
      n++;
    end
    check("scrub_found_ce", 64'(si.ce_count), 1);
    repeat (2) @(posedge clk);
    #1;
    si.rs1 = 2; #1;
    check("scrub_r2_data", 64'(si.rd1), 64'h0000_0000_0BAD_F00D);
    check("scrub_r2_clean", 64'({si.rd1_ce, si.rd1_ue}), 0);
    check("scrub_ue_none", 64'(si.ue_count), 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst2_busy", 64'(si.scrub_busy), 0);
    check("rst2_ce_count", 64'(si.ce_count), 0);
    s_idle(); si.we = 1; si.waddr = 2; si.wd = 32'h5555;
    @(posedge clk); #1;
    s_idle(); si.inj_en = 1; si.inj_addr = 2; si.inj_mask = CW'(1) << 3;
    @(posedge clk); #1;
    s_idle();
    n = 0;
    while (si.ce_count == 0 && n < 96) begin
      @(posedge clk); #1;
      n++;
    end
    check("wb_reached", 64'({si.scrub_busy, si.ce_count}), 64'h1_0001);
    si.we = 1; si.waddr = 2; si.wd = 32'h1234;
    @(posedge clk); #1;
    s_idle(); si.rs1 = 2; si.inj_en = 1; si.inj_addr = 3; si.inj_mask = CW'(1) << 10; #1;
    check("wb_abandon_data", 64'(si.rd1), 64'h1234);
    check("wb_abandon_clean", 64'({si.rd1_ce, si.rd1_ue}), 0);
    check("wb_abandon_idle", 64'(si.scrub_busy), 0);
    @(posedge clk); #1;
    s_idle();
    repeat (4) @(posedge clk);
    #1;
    check("ptr3_rd_busy", 64'({si.scrub_busy, si.ce_count}), 64'h1_0001);
    @(posedge clk); #1;
    check("ptr3_ce", 64'({si.scrub_busy, si.ce_count}), 64'h1_0002);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_wb_busy", 64'(si.scrub_busy), 0);
    check("rst_wb_ce_count", 64'(si.ce_count), 0);
    for (int i = 0; i < NREGS; i++) begin
      si.rs1 = AW'(i); #1;
      check("rst_wb_reg", 64'({si.rd1_ce, si.rd1_ue, si.rd1}), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
